// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction fetch / data memory) arbiter onto one memory bus, with a one-entry
// request buffer per port and a WAIT timeout. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PRIO_PORT      = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s0_request_enable,
  input  logic        s0_mode,
  input  logic [31:0] s0_addr,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wstrb,
  output logic        s0_response_enable,
  output logic [31:0] s0_data,
  input  logic        s1_request_enable,
  input  logic        s1_mode,
  input  logic [31:0] s1_addr,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wstrb,
  output logic        s1_response_enable,
  output logic [31:0] s1_data,
  output logic        m_request_enable,
  output logic        m_mode,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_response_enable,
  input  logic [31:0] m_data,
  output logic [1:0]  grant,
  output logic        err_overflow,
  output logic        err_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic [1:0] onehot(input logic idx);
    onehot = idx ? 2'b10 : 2'b01;
  endfunction

`ifdef MEM_ARB_RR_EN
  function automatic logic pick_port(input logic [1:0] pend, input logic last);
    if (pend == 2'b11) pick_port = ~last;
    else               pick_port = pend[1];
  endfunction
`else
  localparam logic PRIO_SEL = (PRIO_PORT != 0) ? 1'b1 : 1'b0;

  function automatic logic pick_port(input logic [1:0] pend);
    if (pend == 2'b11) pick_port = PRIO_SEL;
    else               pick_port = pend[1];
  endfunction
`endif

  logic [1:0]        req_s;
  logic [1:0]        mode_in_s;
  logic [1:0][31:0]  addr_in_s;
  logic [1:0][31:0]  wdata_in_s;
  logic [1:0][3:0]   wstrb_in_s;

  assign req_s      = {s1_request_enable, s0_request_enable};
  assign mode_in_s  = {s1_mode, s0_mode};
  assign addr_in_s  = {s1_addr, s0_addr};
  assign wdata_in_s = {s1_wdata, s0_wdata};
  assign wstrb_in_s = {s1_wstrb, s0_wstrb};

  state_t            state_r, state_s;
  logic [1:0]        pending_r, pending_s;
  logic [1:0]        buf_mode_r, buf_mode_s;
  logic [1:0][31:0]  buf_addr_r, buf_addr_s;
  logic [1:0][31:0]  buf_wdata_r, buf_wdata_s;
  logic [1:0][3:0]   buf_wstrb_r, buf_wstrb_s;
  logic              owner_r, owner_s;
  logic [CNT_W-1:0]  count_r, count_s;
  logic              m_req_r, m_req_s;
  logic              m_mode_r, m_mode_s;
  logic [31:0]       m_addr_r, m_addr_s;
  logic [31:0]       m_wdata_r, m_wdata_s;
  logic [3:0]        m_wstrb_r, m_wstrb_s;
  logic [1:0]        grant_r, grant_s;
  logic              s0_resp_r, s0_resp_s;
  logic              s1_resp_r, s1_resp_s;
  logic [31:0]       s0_data_r, s0_data_s;
  logic [31:0]       s1_data_r, s1_data_s;
  logic              err_ovf_r, err_ovf_s;
  logic              err_to_r, err_to_s;
  logic              win_s;
  logic              done_s;
  logic [31:0]       done_data_s;
`ifdef MEM_ARB_RR_EN
  logic              last_grant_r, last_grant_s;
`endif

  // Next-state, bus issue, completion routing and per-port buffer capture.
  always_comb begin
    state_s     = state_r;
    pending_s   = pending_r;
    buf_mode_s  = buf_mode_r;
    buf_addr_s  = buf_addr_r;
    buf_wdata_s = buf_wdata_r;
    buf_wstrb_s = buf_wstrb_r;
    owner_s     = owner_r;
    count_s     = count_r;
    m_req_s     = 1'b0;
    m_mode_s    = m_mode_r;
    m_addr_s    = m_addr_r;
    m_wdata_s   = m_wdata_r;
    m_wstrb_s   = m_wstrb_r;
    grant_s     = grant_r;
    s0_resp_s   = 1'b0;
    s1_resp_s   = 1'b0;
    s0_data_s   = s0_data_r;
    s1_data_s   = s1_data_r;
    err_ovf_s   = err_ovf_r;
    err_to_s    = 1'b0;
    done_s      = 1'b0;
    done_data_s = 32'h0000_0000;
`ifdef MEM_ARB_RR_EN
    last_grant_s = last_grant_r;
    win_s        = pick_port(pending_r, last_grant_r);
`else
    win_s        = pick_port(pending_r);
`endif

    case (state_r)
      IDLE: begin
        if (pending_r != 2'b00) begin
          owner_s   = win_s;
          m_req_s   = 1'b1;
          m_mode_s  = buf_mode_r[win_s];
          m_addr_s  = buf_addr_r[win_s];
          m_wdata_s = buf_wdata_r[win_s];
          m_wstrb_s = buf_wstrb_r[win_s];
          grant_s   = onehot(win_s);
          count_s   = {CNT_W{1'b0}};
          state_s   = WAIT;
`ifdef MEM_ARB_RR_EN
          last_grant_s = win_s;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        // A real response in the last counted cycle still beats the timeout.
        if (m_response_enable) begin
          done_s      = 1'b1;
          done_data_s = m_data;
        end else if (count_r == CNT_LAST) begin
          done_s      = 1'b1;
          done_data_s = 32'h0000_0000;
          err_to_s    = 1'b1;
        end else begin
          count_s = count_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (done_s) begin
      pending_s[owner_r] = 1'b0;
      grant_s            = 2'b00;
      state_s            = IDLE;
      if (owner_r) begin
        s1_resp_s = 1'b1;
        s1_data_s = done_data_s;
      end else begin
        s0_resp_s = 1'b1;
        s0_data_s = done_data_s;
      end
    end else begin
      grant_s = grant_s;
    end

    // Capture runs after completion so a coincident new request re-sets pending.
    for (int n = 0; n < 2; n++) begin
      if (req_s[n]) begin
        if (pending_r[n] && !(done_s && (int'(owner_r) == n))) begin
          err_ovf_s = 1'b1;
        end else begin
          pending_s[n]   = 1'b1;
          buf_mode_s[n]  = mode_in_s[n];
          buf_addr_s[n]  = addr_in_s[n];
          buf_wdata_s[n] = wdata_in_s[n];
          buf_wstrb_s[n] = wstrb_in_s[n];
        end
      end else begin
        pending_s[n] = pending_s[n];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      pending_r   <= 2'b00;
      buf_mode_r  <= 2'b00;
      buf_addr_r  <= {2{32'h0000_0000}};
      buf_wdata_r <= {2{32'h0000_0000}};
      buf_wstrb_r <= {2{4'h0}};
      owner_r     <= 1'b0;
      count_r     <= {CNT_W{1'b0}};
      m_req_r     <= 1'b0;
      m_mode_r    <= 1'b0;
      m_addr_r    <= 32'h0000_0000;
      m_wdata_r   <= 32'h0000_0000;
      m_wstrb_r   <= 4'h0;
      grant_r     <= 2'b00;
      s0_resp_r   <= 1'b0;
      s1_resp_r   <= 1'b0;
      s0_data_r   <= 32'h0000_0000;
      s1_data_r   <= 32'h0000_0000;
      err_ovf_r   <= 1'b0;
      err_to_r    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      pending_r   <= pending_s;
      buf_mode_r  <= buf_mode_s;
      buf_addr_r  <= buf_addr_s;
      buf_wdata_r <= buf_wdata_s;
      buf_wstrb_r <= buf_wstrb_s;
      owner_r     <= owner_s;
      count_r     <= count_s;
      m_req_r     <= m_req_s;
      m_mode_r    <= m_mode_s;
      m_addr_r    <= m_addr_s;
      m_wdata_r   <= m_wdata_s;
      m_wstrb_r   <= m_wstrb_s;
      grant_r     <= grant_s;
      s0_resp_r   <= s0_resp_s;
      s1_resp_r   <= s1_resp_s;
      s0_data_r   <= s0_data_s;
      s1_data_r   <= s1_data_s;
      err_ovf_r   <= err_ovf_s;
      err_to_r    <= err_to_s;
`ifdef MEM_ARB_RR_EN
      last_grant_r <= last_grant_s;
`endif
    end
  end

  assign m_request_enable   = m_req_r;
  assign m_mode             = m_mode_r;
  assign m_addr             = m_addr_r;
  assign m_wdata            = m_wdata_r;
  assign m_wstrb            = m_wstrb_r;
  assign grant              = grant_r;
  assign s0_response_enable = s0_resp_r;
  assign s1_response_enable = s1_resp_r;
  assign s0_data            = s0_data_r;
  assign s1_data            = s1_data_r;
  assign err_overflow       = err_ovf_r;
  assign err_timeout        = err_to_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table of single transactions plus
// hand-written sequences for arbitration, overflow, back-to-back, timeout and reset.
module tb_mem_bus_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s0_request_enable = 1'b0, s0_mode = 1'b0;
  logic [31:0] s0_addr = 32'h0, s0_wdata = 32'h0;
  logic [3:0]  s0_wstrb = 4'h0;
  logic        s0_response_enable;
  logic [31:0] s0_data;
  logic        s1_request_enable = 1'b0, s1_mode = 1'b0;
  logic [31:0] s1_addr = 32'h0, s1_wdata = 32'h0;
  logic [3:0]  s1_wstrb = 4'h0;
  logic        s1_response_enable;
  logic [31:0] s1_data;
  logic        m_request_enable, m_mode;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_response_enable = 1'b0;
  logic [31:0] m_data = 32'h0;
  logic [1:0]  grant;
  logic        err_overflow, err_timeout;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .PRIO_PORT(1)) dut (
    .clk(clk), .rstn(rstn),
    .s0_request_enable(s0_request_enable), .s0_mode(s0_mode), .s0_addr(s0_addr),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_response_enable(s0_response_enable),
    .s0_data(s0_data),
    .s1_request_enable(s1_request_enable), .s1_mode(s1_mode), .s1_addr(s1_addr),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_response_enable(s1_response_enable),
    .s1_data(s1_data),
    .m_request_enable(m_request_enable), .m_mode(m_mode), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_response_enable(m_response_enable),
    .m_data(m_data), .grant(grant), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  typedef struct {
    logic        port;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    logic [31:0] rdata;
    logic        timeout;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        timeout;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   checks = 0;
  int   failures = 0;
  logic last_port = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic p, input logic md, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws);
    if (p) begin
      s1_request_enable = 1'b1; s1_mode = md; s1_addr = a; s1_wdata = wd; s1_wstrb = ws;
    end else begin
      s0_request_enable = 1'b1; s0_mode = md; s0_addr = a; s0_wdata = wd; s0_wstrb = ws;
    end
  endtask

  task automatic clear_req();
    s0_request_enable = 1'b0; s0_mode = 1'b0; s0_addr = 32'h0; s0_wdata = 32'h0; s0_wstrb = 4'h0;
    s1_request_enable = 1'b0; s1_mode = 1'b0; s1_addr = 32'h0; s1_wdata = 32'h0; s1_wstrb = 4'h0;
  endtask

  task automatic push_exp(input logic p, input logic [31:0] d, input logic t);
    exp_t e;
    e.port = p; e.data = d; e.timeout = t;
    sb.push_back(e);
  endtask

  task automatic issue_check(input logic p, input logic md, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] ws);
    check("issue_mreq", {31'd0, m_request_enable}, 32'd1);
    check("issue_addr", m_addr, a);
    check("issue_mode", {31'd0, m_mode}, {31'd0, md});
    check("issue_wdata", m_wdata, wd);
    check("issue_wstrb", {28'd0, m_wstrb}, {28'd0, ws});
    check("issue_grant", {30'd0, grant}, p ? 32'd2 : 32'd1);
    last_port = p;
  endtask

  task automatic respond(input logic [31:0] d);
    m_response_enable = 1'b1;
    m_data = d;
    tick();
    m_response_enable = 1'b0;
    m_data = 32'hBAD0_BAD0;
  endtask

  task automatic expect_done();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      if (s0_response_enable || s1_response_enable) begin
        failures++;
        $display("FAIL done_unexpected: got response with empty scoreboard at %0t", $time);
      end
    end else begin
      e = sb.pop_front();
      check("done_port", {30'd0, s1_response_enable, s0_response_enable}, e.port ? 32'd2 : 32'd1);
      check("done_data", e.port ? s1_data : s0_data, e.data);
      check("done_timeout", {31'd0, err_timeout}, {31'd0, e.timeout});
      check("done_grant", {30'd0, grant}, 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    drive_req(v.port, v.mode, v.addr, v.wdata, v.wstrb);
    push_exp(v.port, v.timeout ? 32'h0 : v.rdata, v.timeout);
    tick();
    clear_req();
    check("lat_early", {31'd0, m_request_enable}, 32'd0);
    tick();
    issue_check(v.port, v.mode, v.addr, v.wdata, v.wstrb);
    if (v.timeout) begin
      n = 0;
      while (!(s0_response_enable || s1_response_enable) && n < 20) begin
        tick();
        n++;
      end
      check("timeout_cycles", n, TO);
    end else begin
      repeat (v.delay) tick();
      respond(v.rdata);
    end
    check("addr_hold", m_addr, v.addr);
    expect_done();
    tick();
    check("resp_one_cycle", {30'd0, s1_response_enable, s0_response_enable}, 32'd0);
    check("timeout_one_cycle", {31'd0, err_timeout}, 32'd0);
  endtask

  task automatic outputs_zero();
    check("rst_mreq", {31'd0, m_request_enable}, 32'd0);
    check("rst_maddr", m_addr, 32'd0);
    check("rst_mwdata", m_wdata, 32'd0);
    check("rst_mmode_wstrb", {27'd0, m_mode, m_wstrb}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_sdata0", s0_data, 32'd0);
    check("rst_sdata1", s1_data, 32'd0);
    check("rst_flags", {28'd0, s1_response_enable, s0_response_enable, err_overflow, err_timeout}, 32'd0);
  endtask

  task automatic issue_simul(input logic p);
    if (p) issue_check(1'b1, 1'b1, 32'h3000, 32'h1234_5678, 4'hF);
    else   issue_check(1'b0, 1'b0, 32'h2000, 32'h0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic first;
    vecs[0] = '{port:1'b0, mode:1'b0, addr:32'h1000,      wdata:32'h0,         wstrb:4'h0, delay:3, rdata:32'hDEAD_BEEF, timeout:1'b0};
    vecs[1] = '{port:1'b1, mode:1'b1, addr:32'h3000,      wdata:32'h1234_5678, wstrb:4'hF, delay:1, rdata:32'hA5A5_A5A5, timeout:1'b0};
    vecs[2] = '{port:1'b1, mode:1'b0, addr:32'hFFFF_FFFC, wdata:32'h0,         wstrb:4'h0, delay:0, rdata:32'h0123_4567, timeout:1'b0};
    vecs[3] = '{port:1'b0, mode:1'b1, addr:32'h0,         wdata:32'hFFFF_FFFF, wstrb:4'h5, delay:TO-1, rdata:32'h7777_0007, timeout:1'b0};
    vecs[4] = '{port:1'b0, mode:1'b0, addr:32'h4000,      wdata:32'h0,         wstrb:4'h0, delay:0, rdata:32'h0, timeout:1'b1};
    vecs[5] = '{port:1'b1, mode:1'b0, addr:32'h5000,      wdata:32'h0,         wstrb:4'h0, delay:0, rdata:32'h0, timeout:1'b1};

    repeat (2) tick();
    outputs_zero();
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      tick();
    end

    // Simultaneous requests: priority port first, the other two cycles after completion.
`ifdef MEM_ARB_RR_EN
    first = ~last_port;
`else
    first = 1'b1;
`endif
    drive_req(1'b0, 1'b0, 32'h2000, 32'h0, 4'h0);
    drive_req(1'b1, 1'b1, 32'h3000, 32'h1234_5678, 4'hF);
    push_exp(first, first ? 32'h1111_0001 : 32'h2222_0000, 1'b0);
    push_exp(~first, first ? 32'h2222_0000 : 32'h1111_0001, 1'b0);
    tick();
    clear_req();
    tick();
    issue_simul(first);
    tick();
    respond(first ? 32'h1111_0001 : 32'h2222_0000);
    expect_done();
    check("simul_gap", {31'd0, m_request_enable}, 32'd0);
    tick();
    issue_simul(~first);
    respond(first ? 32'h2222_0000 : 32'h1111_0001);
    expect_done();
    tick();

    // Request coinciding with its own port's completion, then a re-request right after.
    drive_req(1'b1, 1'b0, 32'h8000, 32'h0, 4'h0);
    push_exp(1'b1, 32'hC0DE_0001, 1'b0);
    tick();
    clear_req();
    tick();
    issue_check(1'b1, 1'b0, 32'h8000, 32'h0, 4'h0);
    m_response_enable = 1'b1;
    m_data = 32'hC0DE_0001;
    drive_req(1'b1, 1'b1, 32'h8800, 32'hCAFE_F00D, 4'h3);
    push_exp(1'b1, 32'hC0DE_0002, 1'b0);
    tick();
    clear_req();
    m_response_enable = 1'b0;
    expect_done();
    check("coincide_no_ovf", {31'd0, err_overflow}, 32'd0);
    tick();
    issue_check(1'b1, 1'b1, 32'h8800, 32'hCAFE_F00D, 4'h3);
    respond(32'hC0DE_0002);
    expect_done();
    tick();
    run_vec('{port:1'b1, mode:1'b0, addr:32'h9000, wdata:32'h0, wstrb:4'h0, delay:2, rdata:32'h9999_0000, timeout:1'b0});
    check("b2b_no_ovf", {31'd0, err_overflow}, 32'd0);
    tick();

    // Overflow: second s1 request while the first waits behind an s0 transaction.
    drive_req(1'b0, 1'b0, 32'h6100, 32'h0, 4'h0);
    push_exp(1'b0, 32'h6100_6100, 1'b0);
    tick();
    clear_req();
    tick();
    issue_check(1'b0, 1'b0, 32'h6100, 32'h0, 4'h0);
    drive_req(1'b1, 1'b0, 32'h6000, 32'h0, 4'h0);
    push_exp(1'b1, 32'h6000_6000, 1'b0);
    tick();
    clear_req();
    drive_req(1'b1, 1'b1, 32'h7000, 32'hBADB_AD00, 4'hF);
    tick();
    clear_req();
    check("ovf_set", {31'd0, err_overflow}, 32'd1);
    check("wait_addr_hold", m_addr, 32'h6100);
    respond(32'h6100_6100);
    expect_done();
    tick();
    issue_check(1'b1, 1'b0, 32'h6000, 32'h0, 4'h0);
    respond(32'h6000_6000);
    expect_done();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ovf_dropped", {31'd0, m_request_enable}, 32'd0);
    end
    check("ovf_sticky", {31'd0, err_overflow}, 32'd1);

    // Asynchronous reset in the middle of WAIT, then a stray bus response.
    drive_req(1'b0, 1'b0, 32'h4444, 32'h0, 4'h0);
    push_exp(1'b0, 32'h4444_0000, 1'b0);
    tick();
    clear_req();
    tick();
    issue_check(1'b0, 1'b0, 32'h4444, 32'h0, 4'h0);
    tick();
    #3 rstn = 1'b0;
    #1 outputs_zero();
    sb.delete();
    @(posedge clk);
    #2 rstn = 1'b1;
    tick();
    m_response_enable = 1'b1;
    m_data = 32'h5555_5555;
    tick();
    m_response_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("stray_resp", {30'd0, s1_response_enable, s0_response_enable}, 32'd0);
      check("stray_grant", {29'd0, m_request_enable, grant}, 32'd0);
      tick();
    end
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single core memory bus between two requesters: port 0 is instruction fetch and port 1 is the data memory stage.
- Each requester issues a one-cycle request pulse with mode/addr/wdata/wstrb.
- The arbiter buffers one request per port, issues them to the bus one at a time, and routes the response pulse and data back to the owner.
- It sits between the fetch/mem stages and the MMU/cache bus master.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles in WAIT before the transaction is force-completed with an error.
PRIO_PORT, 1, port that wins simultaneous pending requests in fixed-priority mode.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s0_request_enable  in  1  port-0 request pulse
s0_mode  in  1  port-0 read(0)/write(1)
s0_addr  in  32  port-0 word address
s0_wdata  in  32  port-0 write data
s0_wstrb  in  4  port-0 byte strobes
s0_response_enable  out  1  port-0 completion pulse
s0_data  out  32  port-0 read data
s1_request_enable, s1_mode, s1_addr, s1_wdata, s1_wstrb, s1_response_enable, s1_data  same widths/directions as the port-0 equivalents, for port 1
m_request_enable  out  1  bus request pulse
m_mode  out  1  bus mode
m_addr  out  32  bus address
m_wdata  out  32  bus write data
m_wstrb  out  4  bus strobes
m_response_enable  in  1  bus completion pulse
m_data  in  32  bus read data
grant  out  2  one-hot owner of the current transaction; 0 when idle
err_overflow  out  1  sticky: a request arrived on a port whose buffer was already full
err_timeout  out  1  one-cycle pulse when a timeout fires

Behaviour:
- Reset (async, rstn=0): state=IDLE; pending[1:0]=0; all outputs 0, including m_*, s*_data, grant and both error flags; timeout counter 0. Applies mid-transaction: the in-flight transaction is abandoned, and a late m_response_enable after reset release is ignored while in IDLE.
- Per-port buffer, one entry:
  - sN_request_enable=1 latches mode/addr/wdata/wstrb and sets pending[N].
  - If pending[N] is already 1 and the port is not completing this cycle: the request is dropped, the buffer is unchanged, err_overflow is set (sticky until reset).
  - Set wins over clear when a request and that port's completion coincide.
- State machine:
  - IDLE: if any pending, select the winner, register m_* from its buffer, m_request_enable=1, grant=onehot(winner), timeout counter=0, go to WAIT.
  - WAIT: m_request_enable=0. When m_response_enable=1: register sW_data=m_data, sW_response_enable=1 for exactly one cycle, clear pending[W], grant=0, go to IDLE. Otherwise increment the counter.
  - On counter reaching TIMEOUT_CYCLES-1: complete the transaction as above with sW_data=0, err_timeout pulses for 1 cycle, go to IDLE.
- Latency:
  - Request pulse at cycle N: the buffer is set at the edge ending N, and m_request_enable is high during N+2 on an idle bus.
  - m_response_enable at cycle k: sW_response_enable and sW_data are valid during k+1.
  - The next grant is issued from IDLE at k+1, so m_request_enable is high at k+2.
- Non-owner s*_data holds its last value; s*_response_enable is 0 except in the completion cycle.
- m_addr, m_wdata, m_mode and m_wstrb hold their values through WAIT until the next grant.
- Requests arriving during WAIT are buffered and do not disturb the current transaction.
- Fixed priority (default): PRIO_PORT wins when both ports are pending.

Optional Feature:
MEM_ARB_RR_EN:
- Defined: round-robin arbitration. A last_grant register (reset 0) records the most recently granted port. When both ports are pending, the port not equal to last_grant wins. PRIO_PORT is ignored.
- Undefined: fixed priority per PRIO_PORT. The last_grant register is absent.

Test Plan:
1. Single read: s0 request addr=0x1000 mode=0 at cycle 2 → m_request_enable at cycle 4 with m_addr=0x1000, grant=01. m_response_enable with m_data=0xDEADBEEF at cycle 7 → s0_response_enable=1 and s0_data=0xDEADBEEF at cycle 8 only.
2. Simultaneous requests: s0 read 0x2000 and s1 write 0x3000 (wdata=0x12345678, wstrb=1111) in the same cycle, default build → s1 issued first; s0 issued 2 cycles after s1's completion. With MEM_ARB_RR_EN, repeated simultaneous requests alternate 1,0,1,0.
3. Overflow: s1 issues a second request while its first is pending → err_overflow=1 and stays 1; the first request's address is still the one issued.
4. Timeout with TIMEOUT_CYCLES=8: s0 read with no bus response → after 8 WAIT cycles, s0_response_enable=1, s0_data=0, err_timeout pulses; arbiter returns to IDLE and serves the next request normally.
5. Reset mid-WAIT: assert rstn=0 asynchronously during WAIT → all outputs 0 immediately. After release, a stray m_response_enable produces no s*_response_enable.
6. Back-to-back: s1 re-requests in the cycle after its s1_response_enable → accepted without overflow; m_request_enable is high 2 cycles later.
